// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch -> decode instruction buffer.
package fetch_queue_pkg;

  // One completed fetch: program counter plus raw 32-bit instruction word.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  import fetch_queue_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          fetch_pending;
  logic          in_valid;
  fetch_data_t   in_data;
  logic          in_ready;
  logic          out_valid;
  fetch_data_t   out_data;
  logic          out_ready;
  logic [CW-1:0] occupancy;
  logic          overflow;

  // Fetch/decode/redirect side drives the requests and consumes status.
  modport master (
    output flush, fetch_pending, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, overflow
  );

  // The queue itself.
  modport slave (
    input  flush, fetch_pending, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, overflow
  );
endinterface : fetch_queue_if

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode. A flush empties it
// and, if an old-path response is still outstanding, swallows that response.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);
  import fetch_queue_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] RDY_CNT  = CW'(DEPTH - 1);

  typedef logic [PW-1:0] fetchq_ptr_t;

  fetch_data_t   mem_q [DEPTH];
  fetchq_ptr_t   head_q, head_d;
  fetchq_ptr_t   tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          full, enq, deq;

  // Handshake outputs and next-state; flush beats enqueue and dequeue.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    full   = (cnt_q == FULL_CNT);

    // Ready keeps one slot spare for the fetch already launched when it drops.
    bus.in_ready  = (cnt_q < RDY_CNT);
    bus.out_valid = (cnt_q != '0) && !bus.flush;
    bus.out_data  = mem_q[head_q];
    bus.occupancy = cnt_q;
    bus.overflow  = ovf_q;

    enq = bus.in_valid && !bus.flush && !drop_q && !full;
    deq = bus.out_valid && bus.out_ready;

    if (bus.flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      // A response arriving with the flush is the old one itself; otherwise
      // an outstanding request (or an earlier unanswered drop) must be eaten.
      drop_d = !bus.in_valid && (bus.fetch_pending || drop_q);
    end else begin
      if (bus.in_valid && drop_q)
        drop_d = 1'b0;
      else if (bus.in_valid && full)
        ovf_d = 1'b1;
      if (enq) tail_d = tail_q + fetchq_ptr_t'(1);
      if (deq) head_d = head_q + fetchq_ptr_t'(1);
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers and entry storage, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      if (enq) mem_q[tail_q] <= bus.in_data;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  fetch_data_t mq[$];
  bit          m_drop = 1'b0;
  bit          m_ovf  = 1'b0;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.flush         = 1'b0;
    bus.fetch_pending = 1'b0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
  endtask

  // One clock: drive at posedge+1, check against the model before the next
  // edge, then advance the model at the edge.
  task automatic cyc(input bit fl, input bit pend, input bit iv,
                     input logic [63:0] pc, input bit ordy);
    bit acc, pop;
    fetch_data_t d;
    bus.flush         = fl;
    bus.fetch_pending = pend;
    bus.in_valid      = iv;
    bus.in_data       = '{pc: pc, raw_instr: $urandom()};
    bus.out_ready     = ordy;
    d = bus.in_data;
    #3;
    check("out_valid", 96'(bus.out_valid), 96'((mq.size() != 0) && !fl));
    check("in_ready",  96'(bus.in_ready),  96'(mq.size() < DEPTH - 1));
    check("occupancy", 96'(bus.occupancy), 96'(mq.size()));
    check("overflow",  96'(bus.overflow),  96'(m_ovf));
    if (mq.size() != 0) check("out_data", bus.out_data, mq[0]);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_drop = !iv && (pend || m_drop);
    end else begin
      acc = iv && !m_drop && (mq.size() < DEPTH);
      pop = ordy && (mq.size() != 0);
      if (iv && m_drop) m_drop = 1'b0;
      else if (iv && mq.size() == DEPTH) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    #1;
  endtask

  // Reset pulse between clock edges; outputs must clear without an edge.
  task automatic async_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 96'(bus.out_valid), 96'(0));
    check("rst_occupancy", 96'(bus.occupancy), 96'(0));
    check("rst_in_ready",  96'(bus.in_ready),  96'(1));
    check("rst_overflow",  96'(bus.overflow),  96'(0));
    check("rst_out_data",  bus.out_data,       96'(0));
    mq.delete();
    m_drop = 1'b0;
    m_ovf  = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    bus.in_data = '0;
    #1;
    check("init_out_valid", 96'(bus.out_valid), 96'(0));
    check("init_in_ready",  96'(bus.in_ready),  96'(1));
    check("init_occupancy", 96'(bus.occupancy), 96'(0));
    check("init_overflow",  96'(bus.overflow),  96'(0));
    check("init_out_data",  bus.out_data,       96'(0));
    #11 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 64'h8000_0000 + 64'(4 * i), 0);
    idle_inputs();
    #1;
    check("fill_occupancy", 96'(bus.occupancy), 96'(4));
    check("fill_in_ready",  96'(bus.in_ready),  96'(0));
    check("fill_head_pc",   96'(bus.out_data.pc), 96'(64'h8000_0000));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

    // Streaming: one in, one out per cycle; pointers wrap twice.
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 64'h4000 + 64'(4 * i), 1);
    cyc(0, 0, 0, 0, 1);

    // Flush with an outstanding request: next response is discarded.
    cyc(0, 0, 1, 64'h500, 0);
    cyc(0, 0, 1, 64'h504, 0);
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 1, 64'h1000, 0);
    idle_inputs();
    #1;
    check("flush_drop_occ", 96'(bus.occupancy), 96'(0));
    cyc(0, 0, 1, 64'h2000, 0);
    idle_inputs();
    #1;
    check("flush_next_valid", 96'(bus.out_valid),   96'(1));
    check("flush_next_pc",    96'(bus.out_data.pc), 96'(64'h2000));
    cyc(0, 0, 0, 0, 1);

    // Flush coincident with a response: response dropped, no drop flag.
    cyc(1, 0, 1, 64'h3000, 0);
    idle_inputs();
    #1;
    check("coinc_occ", 96'(bus.occupancy), 96'(0));
    cyc(0, 0, 1, 64'h3004, 0);
    idle_inputs();
    #1;
    check("coinc_next_occ", 96'(bus.occupancy),   96'(1));
    check("coinc_next_pc",  96'(bus.out_data.pc), 96'(64'h3004));
    cyc(0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(15) == 0), $urandom_range(1), ($urandom_range(9) < 6),
          {32'h0, $urandom()}, $urandom_range(1));

    // Async reset mid-stream with three entries.
    async_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 64'h6000 + 64'(4 * i), 0);
    async_reset();
    cyc(0, 0, 1, 64'h7000, 0);
    cyc(0, 0, 0, 0, 1);

    // Overflow: enqueue into a full queue.
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 64'h8000_0000 + 64'(4 * i), 0);
    cyc(0, 0, 1, 64'h9999_0000, 0);
    idle_inputs();
    #1;
    check("ovf_flag", 96'(bus.overflow),   96'(1));
    check("ovf_occ",  96'(bus.occupancy),  96'(4));
    check("ovf_head", 96'(bus.out_data.pc), 96'(64'h8000_0000));
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);

    async_reset();
    for (int i = 0; i < 200; i++)
      cyc(($urandom_range(15) == 0), $urandom_range(1), ($urandom_range(9) < 5),
          {32'h0, $urandom()}, ($urandom_range(3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and decode. Captures each completed fetch (pc plus 32-bit raw instruction) into a small circular FIFO, presents the oldest entry to decode with a valid/ready handshake, and decouples memory-latency bubbles from decode stalls. On a redirect (branch or trap) it empties itself and discards the one response still in flight from the old path.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  redirect from execute/CSR; empties queue, discards same-cycle enqueue
- fetch_pending  in  1  fetch has an outstanding ibus request not yet finished (ireq.valid && !finish_pc)
- in_valid  in  1  fetch completed this cycle (finish_pc)
- in_data  in  fetch_data_t  {pc u64, raw_instr u32} from fetch
- in_ready  out  1  upstream may start a new fetch
- out_valid  out  1  head entry valid for decode
- out_data  out  fetch_data_t  head entry
- out_ready  in  1  decode accepts head this cycle
- occupancy  out  $clog2(DEPTH+1)  current entry count
- overflow  out  1  sticky: enqueue attempted while full

## Operation
- Storage: DEPTH × fetch_data_t array; head, tail pointers of $clog2(DEPTH) bits, wrap naturally mod DEPTH; count of $clog2(DEPTH+1) bits.
- enq = in_valid && !flush && !drop_next && count != DEPTH; deq = out_valid && out_ready.
- enq: array[tail] <= in_data, tail+1. deq: head+1. Both: count unchanged; otherwise count ±1.
- in_ready = count < DEPTH-1 (one slot reserved for the fetch already in flight when ready drops).
- out_valid = (count != 0) && !flush; out_data = array[head] (combinational read, no bypass from in_data).
- flush (highest priority): head, tail, count <= 0; any same-cycle in_valid and deq ignored.
- drop_next flag: set on flush when fetch_pending && !in_valid (old-path response still coming); while set, next in_valid is discarded and clears the flag. A second flush while set keeps it set. in_valid coinciding with flush is already the old response → flag not set.
- in_valid with count == DEPTH (protocol violation): data discarded, overflow <= 1 until reset.

## Timing
- Reset values: out_valid 0, in_ready 1, occupancy 0, overflow 0, out_data 0 (array cleared), drop_next 0, pointers 0.
- Enqueue at edge N → out_valid high from cycle N+1; min latency 1 cycle, throughput 1 instr/cycle.
- in_ready, occupancy: function of registered count only (no combinational path from in_valid/out_ready).
- out_valid deasserts in the flush cycle itself (combinational gate); queue empty from following cycle.
- Reset asserted mid-operation: all state cleared immediately, independent of clk; in-flight response after reset deasserts is accepted normally (fetch is reset too).
- Wrap-around: tail from DEPTH-1 to 0 with no bubble; full/empty distinguished by count, not pointer equality.

## Structure
- fetch_data_t already in pipes package; add fetchq_ptr_t / width localparams derived from DEPTH locally, no new package constants.
- No sub-module needed; single module with one always_ff (async reset) for pointers/count/flags/array and one always_comb for handshake signals.

## Test plan
- Fill: out_ready=0, 4 back-to-back in_valid pc 0x8000_0000..0x8000_000C → occupancy 4, in_ready low after count reaches 3, out_data.pc=0x8000_0000.
- Streaming: in_valid and out_ready every cycle for 10 instrs → occupancy stays 1, pcs emerge in order one cycle after entry, pointers wrap twice.
- Flush with pending: 2 entries, fetch_pending=1, flush pulse, next in_valid pc 0x1000 → discarded, occupancy 0; following in_valid pc 0x2000 → out_data.pc=0x2000.
- Flush coincident with in_valid: in_valid pc 0x3000 same cycle as flush → not enqueued, drop_next not set, next in_valid accepted.
- Overflow: force in_valid with count 4 → entry discarded, overflow=1, existing 4 entries drain unchanged.
- Async reset mid-stream with 3 entries: reset pulse between edges → out_valid=0, occupancy=0, in_ready=1 immediately.
